// File: rtl/bsg_wb_burst_master.sv
// Wishbone B4 registered-feedback burst master: one command becomes one CTI/BTE-sequenced cycle.
// Optional watchdog abort on a stalled slave: define BSG_WB_BURST_MASTER_TIMEOUT_EN.
module bsg_wb_burst_master #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int timeout_p    = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic                      cmd_we_i,
    input  logic [3:0]                cmd_len_i,
    input  logic [1:0]                cmd_bte_i,
    input  logic [data_width_p-1:0]   wdata_i,
    input  logic [data_width_p/8-1:0] wsel_i,
    input  logic                      wdata_v_i,
    output logic                      wdata_yumi_o,
    output logic [data_width_p-1:0]   rdata_o,
    output logic                      rdata_v_o,
    output logic                      resp_v_o,
    output logic                      resp_err_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [addr_width_p-1:0]   adr_o,
    output logic [data_width_p-1:0]   dat_o,
    output logic [data_width_p/8-1:0] sel_o,
    output logic [2:0]                cti_o,
    output logic [1:0]                bte_o,
    input  logic [data_width_p-1:0]   dat_i,
    input  logic                      ack_i,
    input  logic                      err_i
);
    localparam int wb_lp = data_width_p / 8;
    localparam int lg_lp = $clog2(wb_lp);
    localparam logic [addr_width_p-1:0] low_mask_lp = addr_width_p'((64'd1 << lg_lp) - 64'd1);
    localparam logic [addr_width_p-1:0] wrap4_lp    = addr_width_p'(3);
    localparam logic [addr_width_p-1:0] wrap8_lp    = addr_width_p'(7);
    localparam logic [addr_width_p-1:0] wrap16_lp   = addr_width_p'(15);

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_e;

    state_e     state;
    logic [3:0] beats_left;
    logic       beat_done;
    logic       abort;
    logic       timeout_hit;

    // Word-index stepping; wrap bursts only touch the low log2(N) bits of the index.
    function automatic logic [addr_width_p-1:0] next_adr(input logic [addr_width_p-1:0] a,
                                                         input logic [1:0] bte);
        logic [addr_width_p-1:0] w, inc, wrap;
        w   = a >> lg_lp;
        inc = w + 1'b1;
        case (bte)
            2'b01:   wrap = wrap4_lp;
            2'b10:   wrap = wrap8_lp;
            2'b11:   wrap = wrap16_lp;
            default: wrap = '1;
        endcase
        return ((inc & wrap) | (w & ~wrap)) << lg_lp;
    endfunction

    function automatic logic [3:0] wrap_last(input logic [1:0] bte);
        case (bte)
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    assign cmd_ready_o  = (state == IDLE);
    assign stb_o        = cyc_o & (~we_o | wdata_v_i);
    assign dat_o        = wdata_i;
    assign sel_o        = we_o ? wsel_i : '1;
    assign rdata_o      = dat_i;
    assign beat_done    = stb_o & ack_i & ~err_i;
    assign rdata_v_o    = beat_done & ~we_o;
    assign wdata_yumi_o = beat_done & we_o;
    assign abort        = (cyc_o & err_i) | timeout_hit;

`ifdef BSG_WB_BURST_MASTER_TIMEOUT_EN
    localparam int tw_lp = (timeout_p > 2) ? $clog2(timeout_p) : 1;
    logic [tw_lp-1:0] stall_cnt;
    logic             stall;

    assign stall       = stb_o & ~ack_i & ~err_i;
    assign timeout_hit = stall & (stall_cnt == tw_lp'(timeout_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            stall_cnt <= '0;
        else if (stall && !timeout_hit)
            stall_cnt <= stall_cnt + 1'b1;
        else
            stall_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            cyc_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            cti_o      <= 3'b000;
            bte_o      <= 2'b00;
            beats_left <= 4'd0;
            resp_v_o   <= 1'b0;
            resp_err_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_v_o <= 1'b0;
                    if (cmd_v_i) begin
                        state      <= BURST;
                        cyc_o      <= 1'b1;
                        we_o       <= cmd_we_i;
                        adr_o      <= cmd_addr_i & ~low_mask_lp;
                        beats_left <= cmd_len_i;
                        cti_o      <= (cmd_len_i == 4'd0) ? 3'b000 : 3'b010;
                        bte_o      <= (cmd_len_i == 4'd0) ? 2'b00 : cmd_bte_i;
                    end
                end
                BURST: begin
                    if (abort || (beat_done && beats_left == 4'd0)) begin
                        state      <= RESP;
                        cyc_o      <= 1'b0;
                        we_o       <= 1'b0;
                        resp_v_o   <= 1'b1;
                        resp_err_o <= abort;
                    end else if (beat_done) begin
                        adr_o      <= next_adr(adr_o, bte_o);
                        beats_left <= beats_left - 4'd1;
                        cti_o      <= (beats_left == 4'd1) ? 3'b011 : 3'b010;
                    end
                end
                default: begin
                    state    <= IDLE;
                    resp_v_o <= 1'b0;
                    cti_o    <= 3'b000;
                    bte_o    <= 2'b00;
                end
            endcase
        end
    end

    wrap_len_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (cmd_v_i && cmd_ready_o && cmd_bte_i != 2'b00) |-> (cmd_len_i == wrap_last(cmd_bte_i)));

    params_a: assert property (@(posedge clk_i) (timeout_p > 1) && (data_width_p >= 8));

endmodule

// File: tb/tb_bsg_wb_burst_master.sv
// Directed bench for bsg_wb_burst_master; the Wishbone slave side is driven by hand, beat by beat.
module tb_bsg_wb_burst_master;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        cmd_v_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [3:0]  cmd_len_i;
    logic [1:0]  cmd_bte_i;
    logic [63:0] wdata_i, rdata_o, dat_o, dat_i;
    logic [7:0]  wsel_i, sel_o;
    logic        wdata_v_i, wdata_yumi_o, rdata_v_o, resp_v_o, resp_err_o;
    logic        cyc_o, stb_o, we_o, ack_i, err_i;
    logic [31:0] adr_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;

    int errors = 0;
    int checks = 0;

    bsg_wb_burst_master #(.addr_width_p(32), .data_width_p(64), .timeout_p(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_len_i(cmd_len_i), .cmd_bte_i(cmd_bte_i),
        .wdata_i(wdata_i), .wsel_i(wsel_i), .wdata_v_i(wdata_v_i), .wdata_yumi_o(wdata_yumi_o),
        .rdata_o(rdata_o), .rdata_v_o(rdata_v_o), .resp_v_o(resp_v_o), .resp_err_o(resp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .cti_o(cti_o), .bte_o(bte_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Presents a command for one accepting edge; returns in the first BURST cycle.
    task automatic send_cmd(input logic [31:0] a, input logic we, input logic [3:0] len,
                            input logic [1:0] bte);
        cmd_v_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_len_i = len; cmd_bte_i = bte;
        #1;
        check("cmd_ready_idle", cmd_ready_o, 1'b1);
        tick();
        cmd_v_i = 1'b0;
    endtask

    initial begin
        logic [31:0] lin_adr [4];
        logic [31:0] w4_adr  [4];
        logic [31:0] w8_adr  [8];
        logic [2:0]  cti4    [4];
        int          high_cnt;

        lin_adr = '{32'h1F8, 32'h200, 32'h208, 32'h210};
        w4_adr  = '{32'h118, 32'h100, 32'h108, 32'h110};
        w8_adr  = '{32'h230, 32'h238, 32'h200, 32'h208, 32'h210, 32'h218, 32'h220, 32'h228};
        cti4    = '{3'b010, 3'b010, 3'b010, 3'b011};

        reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_len_i = '0;
        cmd_bte_i = '0; wdata_i = '0; wsel_i = '0; wdata_v_i = 1'b0; dat_i = '0;
        ack_i = 1'b0; err_i = 1'b0;
        tick(); tick();
        check("rst_cyc", cyc_o, 1'b0);
        check("rst_stb", stb_o, 1'b0);
        check("rst_resp", resp_v_o, 1'b0);
        check("rst_adr", adr_o, 32'h0);
        check("rst_cti", cti_o, 3'b000);
        check("rst_bte", bte_o, 2'b00);
        reset_n_i = 1'b1;
        tick();

        // Single read, ack on the second BURST cycle
        send_cmd(32'h100, 1'b0, 4'd0, 2'b00);
        #1;
        check("sr_cyc", cyc_o, 1'b1);
        check("sr_stb", stb_o, 1'b1);
        check("sr_adr", adr_o, 32'h100);
        check("sr_cti", cti_o, 3'b000);
        check("sr_ready", cmd_ready_o, 1'b0);
        check("sr_sel", sel_o, 8'hFF);
        check("sr_rv_wait", rdata_v_o, 1'b0);
        tick();
        ack_i = 1'b1; dat_i = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("sr_rv", rdata_v_o, 1'b1);
        check("sr_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
        tick();
        ack_i = 1'b0;
        #1;
        check("sr_cyc_drop", cyc_o, 1'b0);
        check("sr_resp", resp_v_o, 1'b1);
        check("sr_err", resp_err_o, 1'b0);
        check("sr_resp_ready", cmd_ready_o, 1'b0);
        tick();
        check("sr_resp_pulse", resp_v_o, 1'b0);

        // Linear write across a 0x200 boundary, acks every cycle
        send_cmd(32'h1F8, 1'b1, 4'd3, 2'b00);
        for (int i = 0; i < 4; i++) begin
            wdata_i = 64'hA0 + 64'(i); wsel_i = 8'hF0 | 8'(i); wdata_v_i = 1'b1; ack_i = 1'b1;
            #1;
            check("lw_adr", adr_o, lin_adr[i]);
            check("lw_cti", cti_o, cti4[i]);
            check("lw_bte", bte_o, 2'b00);
            check("lw_yumi", wdata_yumi_o, 1'b1);
            check("lw_dat", dat_o, 64'hA0 + 64'(i));
            check("lw_sel", sel_o, 8'hF0 | 8'(i));
            tick();
        end
        wdata_v_i = 1'b0; ack_i = 1'b0;
        #1;
        check("lw_resp", resp_v_o, 1'b1);
        check("lw_err", resp_err_o, 1'b0);
        check("lw_cyc", cyc_o, 1'b0);
        tick();

        // 4-beat wrap read starting at word 0x23
        send_cmd(32'h118, 1'b0, 4'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            ack_i = 1'b1; dat_i = 64'h1000 + 64'(i);
            #1;
            check("w4_adr", adr_o, w4_adr[i]);
            check("w4_cti", cti_o, cti4[i]);
            check("w4_bte", bte_o, 2'b01);
            check("w4_rv", rdata_v_o, 1'b1);
            tick();
        end
        ack_i = 1'b0;
        #1;
        check("w4_resp", resp_v_o, 1'b1);
        tick();

        // 8-beat wrap write with a two-cycle data gap after beat 2
        send_cmd(32'h230, 1'b1, 4'd7, 2'b10);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int g = 0; g < 2; g++) begin
                    wdata_v_i = 1'b0; ack_i = 1'b0;
                    #1;
                    check("w8_gap_stb", stb_o, 1'b0);
                    check("w8_gap_cyc", cyc_o, 1'b1);
                    check("w8_gap_adr", adr_o, w8_adr[3]);
                    check("w8_gap_cti", cti_o, 3'b010);
                    check("w8_gap_yumi", wdata_yumi_o, 1'b0);
                    tick();
                end
            end
            wdata_v_i = 1'b1; wdata_i = 64'h80 + 64'(i); ack_i = 1'b1;
            #1;
            check("w8_adr", adr_o, w8_adr[i]);
            check("w8_cti", cti_o, (i == 7) ? 3'b011 : 3'b010);
            check("w8_bte", bte_o, 2'b10);
            check("w8_yumi", wdata_yumi_o, 1'b1);
            tick();
        end
        wdata_v_i = 1'b0; ack_i = 1'b0;
        #1;
        check("w8_resp", resp_v_o, 1'b1);
        check("w8_err", resp_err_o, 1'b0);
        tick();

        // err_i on beat 2 of a len-7 linear read
        send_cmd(32'h40, 1'b0, 4'd7, 2'b00);
        for (int i = 0; i < 2; i++) begin
            ack_i = 1'b1;
            #1;
            check("er_rv", rdata_v_o, 1'b1);
            tick();
        end
        ack_i = 1'b0; err_i = 1'b1;
        #1;
        check("er_adr", adr_o, 32'h50);
        check("er_rv_err", rdata_v_o, 1'b0);
        tick();
        err_i = 1'b0;
        #1;
        check("er_cyc", cyc_o, 1'b0);
        check("er_resp", resp_v_o, 1'b1);
        check("er_err", resp_err_o, 1'b1);
        tick();

        // ack and err together: err wins, no data pulse
        send_cmd(32'h80, 1'b0, 4'd1, 2'b00);
        ack_i = 1'b1; err_i = 1'b1;
        #1;
        check("ae_rv", rdata_v_o, 1'b0);
        tick();
        ack_i = 1'b0; err_i = 1'b0;
        #1;
        check("ae_resp", resp_v_o, 1'b1);
        check("ae_err", resp_err_o, 1'b1);
        tick();

        // Slave never acks
        send_cmd(32'h8, 1'b0, 4'd0, 2'b00);
        high_cnt = 0;
`ifdef BSG_WB_BURST_MASTER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            if (cyc_o === 1'b1) high_cnt++;
            tick();
        end
        check("to_stall_cycles", 64'(high_cnt), 64'd16);
        check("to_resp", resp_v_o, 1'b1);
        check("to_err", resp_err_o, 1'b1);
        check("to_cyc", cyc_o, 1'b0);
        tick();
`else
        for (int i = 0; i < 40; i++) begin
            if (cyc_o === 1'b1) high_cnt++;
            tick();
        end
        check("hang_cycles", 64'(high_cnt), 64'd40);
        check("hang_resp", resp_v_o, 1'b0);
        reset_n_i = 1'b0;
        #1;
        check("hang_rst_cyc", cyc_o, 1'b0);
        reset_n_i = 1'b1;
        tick();
`endif

        // Reset mid-burst drops cyc_o at once and issues no response
        send_cmd(32'h300, 1'b0, 4'd3, 2'b00);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        #1;
        check("mr_adr", adr_o, 32'h308);
        reset_n_i = 1'b0;
        #1;
        check("mr_cyc", cyc_o, 1'b0);
        check("mr_adr_rst", adr_o, 32'h0);
        check("mr_resp", resp_v_o, 1'b0);
        tick();
        reset_n_i = 1'b1;
        tick();
        check("mr_resp_after", resp_v_o, 1'b0);
        check("mr_ready", cmd_ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
